// File: rtl/output_store.sv
`default_nettype none
// ============================================================================
// Module   : output_store
// Purpose  : Packs pairs of 16-bit accumulator results into 128-bit words and
//            writes them to an output memory at consecutive addresses starting
//            at BASE_ADDR. A frame ends after NUM_WORDS writes, on in_last, or
//            on a standalone flush request; done then pulses for one cycle.
// Ports    : clock, reset       - clock, asynchronous active-high reset
//            start              - frame start (honoured only when idle)
//            in_valid, in_last  - pair qualifier / end-of-frame or flush
//            Accumlate1/2       - result pair (lanes 2k / 2k+1)
//            WriteEnable        - one-cycle write strobe
//            Output_MEMBus      - packed write data
//            Output_MEMAddress  - write address
//            busy, done         - not-idle flag, completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module output_store #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned NUM_WORDS = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic [15:0]  Accumlate1,
    input  logic [15:0]  Accumlate2,
    output logic         WriteEnable,
    output logic [127:0] Output_MEMBus,
    output logic [15:0]  Output_MEMAddress,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t         r_state, w_nxt_state;
    logic [1:0]     r_pair_cnt, w_nxt_pair_cnt;
    logic [15:0]    r_word_cnt, w_nxt_word_cnt;
    logic [15:0]    r_addr, w_nxt_addr;
    logic [127:0]   r_buf, w_nxt_buf;

    logic           w_nxt_we;
    logic [127:0]   w_nxt_bus;
    logic [15:0]    w_nxt_oaddr;
    logic           w_nxt_done;

    logic           w_issue;
    logic [127:0]   w_issue_word;
    logic [127:0]   w_merged;
    logic           w_last_word;

    // Lanes not yet filled are always zero in the buffer, so the incoming pair
    // can simply be OR-ed in at its 32-bit slot.
    assign w_merged    = r_buf | ({96'd0, Accumlate2, Accumlate1} << {r_pair_cnt, 5'd0});
    assign w_last_word = ((32'(r_word_cnt) + 32'd1) == NUM_WORDS);

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_pair_cnt = r_pair_cnt;
        w_nxt_word_cnt = r_word_cnt;
        w_nxt_addr     = r_addr;
        w_nxt_buf      = r_buf;
        w_nxt_we       = 1'b0;
        w_nxt_bus      = Output_MEMBus;
        w_nxt_oaddr    = Output_MEMAddress;
        w_nxt_done     = 1'b0;
        w_issue        = 1'b0;
        w_issue_word   = r_buf;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nxt_addr     = BASE_ADDR;
                    w_nxt_pair_cnt = 2'd0;
                    w_nxt_word_cnt = 16'd0;
                    w_nxt_buf      = 128'd0;
                    w_nxt_state    = COLLECT;
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    if (r_pair_cnt == 2'd3 || in_last) begin
                        w_issue      = 1'b1;
                        w_issue_word = w_merged;
                        if (in_last || w_last_word) begin
                            w_nxt_state = DONE;
                        end
                    end else begin
                        w_nxt_buf      = w_merged;
                        w_nxt_pair_cnt = r_pair_cnt + 2'd1;
                    end
                end else if (in_last) begin
                    // Flush only if something is pending; an empty flush just ends the frame.
                    w_nxt_state = (r_pair_cnt != 2'd0) ? FLUSH : DONE;
                end
            end
            FLUSH: begin
                w_issue      = 1'b1;
                w_issue_word = r_buf;
                w_nxt_state  = DONE;
            end
            DONE: begin
                w_nxt_done  = 1'b1;
                w_nxt_state = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase

        // Issuing a word clears the buffer on the same edge, so a pair arriving
        // during the write cycle starts the next word without a stall.
        if (w_issue) begin
            w_nxt_we       = 1'b1;
            w_nxt_bus      = w_issue_word;
            w_nxt_oaddr    = r_addr;
            w_nxt_addr     = r_addr + 16'd1;
            w_nxt_word_cnt = r_word_cnt + 16'd1;
            w_nxt_buf      = 128'd0;
            w_nxt_pair_cnt = 2'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state           <= IDLE;
            r_pair_cnt        <= 2'd0;
            r_word_cnt        <= 16'd0;
            r_addr            <= 16'd0;
            r_buf             <= 128'd0;
            WriteEnable       <= 1'b0;
            Output_MEMBus     <= 128'd0;
            Output_MEMAddress <= 16'd0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            r_state           <= w_nxt_state;
            r_pair_cnt        <= w_nxt_pair_cnt;
            r_word_cnt        <= w_nxt_word_cnt;
            r_addr            <= w_nxt_addr;
            r_buf             <= w_nxt_buf;
            WriteEnable       <= w_nxt_we;
            Output_MEMBus     <= w_nxt_bus;
            Output_MEMAddress <= w_nxt_oaddr;
            busy              <= (w_nxt_state != IDLE);
            done              <= w_nxt_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_store
// Purpose  : Scoreboard bench for output_store. Two instances share stimulus
//            (BASE_ADDR 16'h0100 and 16'hFFFF, both NUM_WORDS=2); expected
//            write/done events are queued per instance and a negedge monitor
//            pops and compares each event the instances present.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_store;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [15:0]  acc1 = 16'd0;
    logic [15:0]  acc2 = 16'd0;

    logic         we_a, we_b, busy_a, busy_b, done_a, done_b;
    logic [127:0] bus_a, bus_b;
    logic [15:0]  addr_a, addr_b;

    output_store #(.BASE_ADDR(16'h0100), .NUM_WORDS(2)) dut_a (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .in_last(in_last), .Accumlate1(acc1), .Accumlate2(acc2),
        .WriteEnable(we_a), .Output_MEMBus(bus_a), .Output_MEMAddress(addr_a),
        .busy(busy_a), .done(done_a)
    );

    output_store #(.BASE_ADDR(16'hFFFF), .NUM_WORDS(2)) dut_b (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .in_last(in_last), .Accumlate1(acc1), .Accumlate2(acc2),
        .WriteEnable(we_b), .Output_MEMBus(bus_b), .Output_MEMAddress(addr_b),
        .busy(busy_b), .done(done_b)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit           is_done;
        logic [127:0] bus;
        logic [15:0]  addr;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_write(input logic [127:0] bus, input logic [15:0] aa, input logic [15:0] ab);
        ev_t e;
        e.is_done = 1'b0;
        e.bus     = bus;
        e.addr    = aa;
        q_a.push_back(e);
        e.addr    = ab;
        q_b.push_back(e);
    endtask

    task automatic push_done();
        ev_t e;
        e.is_done = 1'b1;
        e.bus     = 128'd0;
        e.addr    = 16'd0;
        q_a.push_back(e);
        q_b.push_back(e);
    endtask

    task automatic observe(input int which, input bit is_done, input logic [127:0] bus,
                           input logic [15:0] addr);
        ev_t e;
        bit  have = 1'b0;
        string tag = (which == 0) ? "dut_a" : "dut_b";
        if (which == 0) begin
            if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
        end else begin
            if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
        end
        if (!have) begin
            tests++;
            fails++;
            $display("FAIL %s unexpected_event: got %s addr %h bus %h expected none",
                     tag, is_done ? "done" : "write", addr, bus);
        end else begin
            check({tag, " event_kind(1=done)"}, {127'd0, is_done}, {127'd0, e.is_done});
            if (!is_done && !e.is_done) begin
                check({tag, " write_bus"}, bus, e.bus);
                check({tag, " write_addr"}, {112'd0, addr}, {112'd0, e.addr});
            end
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (we_a)   observe(0, 1'b0, bus_a, addr_a);
            if (done_a) observe(0, 1'b1, bus_a, addr_a);
            if (we_b)   observe(1, 1'b0, bus_b, addr_b);
            if (done_b) observe(1, 1'b1, bus_b, addr_b);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pair(input logic [15:0] a, input logic [15:0] b, input logic last);
        in_valid = 1'b1;
        acc1     = a;
        acc2     = b;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic flush();
        in_last = 1'b1;
        step();
        in_last = 1'b0;
    endtask

    initial begin
        // Reset values
        idle(3);
        check("reset we_a", {127'd0, we_a}, 128'd0);
        check("reset bus_a", bus_a, 128'd0);
        check("reset addr_a", {112'd0, addr_a}, 128'd0);
        check("reset busy_a", {127'd0, busy_a}, 128'd0);
        check("reset done_a", {127'd0, done_a}, 128'd0);
        reset = 1'b0;
        idle(2);

        // Traffic while idle is ignored: no events, still not busy
        pair(16'h0099, 16'h0099, 1'b0);
        pair(16'h0098, 16'h0098, 1'b1);
        flush();
        idle(2);
        check("idle ignores input busy_a", {127'd0, busy_a}, 128'd0);

        // Two full words back to back, completing the frame; second word wraps on dut_b
        push_write(128'h0008_0007_0006_0005_0004_0003_0002_0001, 16'h0100, 16'hFFFF);
        push_write(128'h0010_000F_000E_000D_000C_000B_000A_0009, 16'h0101, 16'h0000);
        push_done();
        pulse_start();
        check("busy after start", {127'd0, busy_a}, 128'd1);
        for (int k = 0; k < 8; k++) begin
            pair(16'(2 * k + 1), 16'(2 * k + 2), 1'b0);
        end
        pair(16'h0EEE, 16'h0EEE, 1'b0);   // lands in DONE, must be ignored
        idle(3);
        check("busy low after frame a", {127'd0, busy_a}, 128'd0);
        check("busy low after frame b", {127'd0, busy_b}, 128'd0);

        // Two pairs then standalone flush
        push_write(128'h0000_0000_0000_0000_000D_000C_000B_000A, 16'h0100, 16'hFFFF);
        push_done();
        pulse_start();
        pair(16'h000A, 16'h000B, 1'b0);
        pair(16'h000C, 16'h000D, 1'b0);
        flush();
        idle(4);

        // Single pair carrying in_last
        push_write(128'h0000_0000_0000_0000_0000_0000_2222_1111, 16'h0100, 16'hFFFF);
        push_done();
        pulse_start();
        pair(16'h1111, 16'h2222, 1'b1);
        idle(4);

        // Empty flush: done without write
        push_done();
        pulse_start();
        flush();
        idle(4);

        // Last word reached together with in_last: one write, one done
        push_write(128'h0038_0037_0036_0035_0034_0033_0032_0031, 16'h0100, 16'hFFFF);
        push_write(128'h0040_003F_003E_003D_003C_003B_003A_0039, 16'h0101, 16'h0000);
        push_done();
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            pair(16'(16'h0031 + 2 * k), 16'(16'h0032 + 2 * k), (k == 7));
        end
        idle(4);

        // start during COLLECT is ignored
        push_write(128'h0058_0057_0056_0055_0054_0053_0052_0051, 16'h0100, 16'hFFFF);
        push_done();
        pulse_start();
        pair(16'h0051, 16'h0052, 1'b0);
        pair(16'h0053, 16'h0054, 1'b0);
        pulse_start();
        pair(16'h0055, 16'h0056, 1'b0);
        pair(16'h0057, 16'h0058, 1'b0);
        flush();
        idle(4);

        // Asynchronous reset mid-frame discards partial word
        pulse_start();
        pair(16'h0061, 16'h0062, 1'b0);
        pair(16'h0063, 16'h0064, 1'b0);
        pair(16'h0065, 16'h0066, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async reset busy_a", {127'd0, busy_a}, 128'd0);
        check("async reset bus_a", bus_a, 128'd0);
        check("async reset addr_a", {112'd0, addr_a}, 128'd0);
        check("async reset we_a", {127'd0, we_a}, 128'd0);
        step();
        reset = 1'b0;
        idle(1);
        push_write(128'h0078_0077_0076_0075_0074_0073_0072_0071, 16'h0100, 16'hFFFF);
        push_done();
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            pair(16'(16'h0071 + 2 * k), 16'(16'h0072 + 2 * k), 1'b0);
        end
        flush();
        idle(5);

        check("pending events dut_a", 128'(q_a.size()), 128'd0);
        check("pending events dut_b", 128'(q_b.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
